// File: rtl/shader_pkg.sv
// Shared encodings and default widths for the shader dispatch/pipeline blocks.
package shader_pkg;

    localparam int unsigned DEF_PC_W   = 8;
    localparam int unsigned DEF_GRP_W  = 8;
    localparam int unsigned DEF_WDOG_W = 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_ISSUE = S_ISSUE,
        ST_RUN   = S_RUN,
        ST_DONE  = S_DONE,
        ST_ERROR = S_ERROR
    } dispatch_state_t;

endpackage

// File: rtl/shader_wdog.sv
// Watchdog: clearable, enabled up-counter flagging the cycle that reaches the limit.
module shader_wdog
    import shader_pkg::*;
#(
    parameter int unsigned         WDOG_W     = DEF_WDOG_W,
    parameter logic [WDOG_W-1:0]   WDOG_LIMIT = WDOG_W'(1000)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    logic [WDOG_W-1:0] cnt;

    // Counter clears on clr, counts while enabled, saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != WDOG_LIMIT)) begin
            cnt <= cnt + WDOG_W'(1);
        end
    end

    // High in the enabled cycle whose increment brings the count to the limit.
    assign tc_c = en && (cnt == (WDOG_LIMIT - WDOG_W'(1)));

endmodule

// File: rtl/shader_dispatch_ctrl.sv
// Kernel launch sequencer: issues one pipeline start per thread group,
// waits for halt, and recovers from hung (watchdog) or aborted kernels.
module shader_dispatch_ctrl
    import shader_pkg::*;
#(
    parameter int unsigned       PC_W       = DEF_PC_W,
    parameter int unsigned       GRP_W      = DEF_GRP_W,
    parameter int unsigned       WDOG_W     = DEF_WDOG_W,
    parameter logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(1000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             launch_valid,
    output logic             launch_ready,
    input  logic [PC_W-1:0]  launch_pc,
    input  logic [GRP_W-1:0] launch_groups,
    input  logic             abort,
    input  logic             err_clear,
    output logic             pipe_start,
    output logic [PC_W-1:0]  pipe_pc,
    output logic [GRP_W-1:0] pipe_group,
    input  logic             pipe_halt,
    output logic             pipe_flush,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [GRP_W-1:0] groups_done
);

    dispatch_state_t state, next_state;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [GRP_W-1:0] groups_q, groups_d;
    logic [GRP_W-1:0] idx_q, idx_d;
    logic [GRP_W-1:0] gdone_d;
    logic             flush_d;
    logic             wdog_clr, wdog_en, wdog_tc_c;

    shader_wdog #(
        .WDOG_W     (WDOG_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk  (clk),
        .rst  (rst),
        .clr  (wdog_clr),
        .en   (wdog_en),
        .tc_c (wdog_tc_c)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath-update decode; abort beats halt beats watchdog.
    always_comb begin
        next_state = state;
        pc_d       = pc_q;
        groups_d   = groups_q;
        idx_d      = idx_q;
        gdone_d    = groups_done;
        flush_d    = 1'b0;
        wdog_clr   = 1'b0;
        wdog_en    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (launch_valid) begin
                    pc_d       = launch_pc;
                    groups_d   = launch_groups;
                    idx_d      = '0;
                    gdone_d    = '0;
                    next_state = (launch_groups != '0) ? ST_ISSUE : ST_DONE;
                end
            end
            ST_ISSUE: begin
                wdog_clr = 1'b1;
                if (abort) begin
                    flush_d    = 1'b1;
                    next_state = ST_IDLE;
                end else begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                wdog_en = 1'b1;
                if (abort) begin
                    flush_d    = 1'b1;
                    next_state = ST_IDLE;
                end else if (pipe_halt) begin
                    gdone_d = groups_done + GRP_W'(1);
                    if (idx_q == (groups_q - GRP_W'(1))) begin
                        next_state = ST_DONE;
                    end else begin
                        idx_d      = idx_q + GRP_W'(1);
                        next_state = ST_ISSUE;
                    end
                end else if (wdog_tc_c) begin
                    flush_d    = 1'b1;
                    next_state = ST_ERROR;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            ST_ERROR: begin
                if (err_clear) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Latches, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= '0;
            groups_q     <= '0;
            idx_q        <= '0;
            groups_done  <= '0;
            pipe_pc      <= '0;
            pipe_group   <= '0;
            pipe_start   <= 1'b0;
            pipe_flush   <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
            launch_ready <= 1'b1;
        end else begin
            pc_q         <= pc_d;
            groups_q     <= groups_d;
            idx_q        <= idx_d;
            groups_done  <= gdone_d;
            pipe_start   <= (next_state == ST_ISSUE);
            pipe_flush   <= flush_d;
            done         <= (next_state == ST_DONE);
            err          <= (next_state == ST_ERROR);
            busy         <= (next_state == ST_ISSUE) || (next_state == ST_RUN);
            launch_ready <= (next_state == ST_IDLE);
            if (next_state == ST_ISSUE) begin
                pipe_pc    <= pc_d;
                pipe_group <= idx_d;
            end
        end
    end

endmodule

// File: tb/tb_shader_dispatch_ctrl.sv
// Scoreboard bench for shader_dispatch_ctrl: stimulus queues expected events
// and status snapshots; a negedge monitor pops and compares them.
module tb_shader_dispatch_ctrl;

    localparam int K_START = 0;
    localparam int K_DONE  = 1;
    localparam int K_FLUSH = 2;

    typedef struct {
        int kind;
        int pc;
        int grp;
        int gd;
        int cyc;
    } evt_t;

    typedef struct {
        int cyc;
        int ready;
        int busy;
        int err;
        int gd;
        int pc;
        int grp;
        int quiet;
    } stat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       launch_valid = 1'b0;
    logic       launch_ready;
    logic [7:0] launch_pc = 8'h00;
    logic [7:0] launch_groups = 8'h00;
    logic       abort = 1'b0;
    logic       err_clear = 1'b0;
    logic       pipe_start;
    logic [7:0] pipe_pc;
    logic [7:0] pipe_group;
    logic       pipe_halt = 1'b0;
    logic       pipe_flush;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] groups_done;

    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    bit    fin_req = 1'b0;
    evt_t  evq[$];
    stat_t stq[$];

    shader_dispatch_ctrl #(
        .PC_W       (8),
        .GRP_W      (8),
        .WDOG_W     (16),
        .WDOG_LIMIT (16'd20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .launch_valid  (launch_valid),
        .launch_ready  (launch_ready),
        .launch_pc     (launch_pc),
        .launch_groups (launch_groups),
        .abort         (abort),
        .err_clear     (err_clear),
        .pipe_start    (pipe_start),
        .pipe_pc       (pipe_pc),
        .pipe_group    (pipe_group),
        .pipe_halt     (pipe_halt),
        .pipe_flush    (pipe_flush),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .groups_done   (groups_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_evt(input int kind);
        evt_t e;
        if (evq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
        end else begin
            e = evq.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            if (kind == K_START) begin
                chk("pipe_pc", int'(pipe_pc), e.pc);
                chk("pipe_group", int'(pipe_group), e.grp);
                chk("busy_at_start", int'(busy), 1);
            end else begin
                chk("groups_done", int'(groups_done), e.gd);
            end
        end
    endtask

    // Monitor: compares events and status snapshots, then owns the summary.
    always @(negedge clk) begin
        stat_t s;
        if (!rst) begin
            if (pipe_start) check_evt(K_START);
            if (done)       check_evt(K_DONE);
            if (pipe_flush) check_evt(K_FLUSH);
        end
        if (stq.size() > 0 && stq[0].cyc == cyc) begin
            s = stq.pop_front();
            chk("launch_ready", int'(launch_ready), s.ready);
            chk("busy", int'(busy), s.busy);
            chk("err", int'(err), s.err);
            chk("groups_done_stat", int'(groups_done), s.gd);
            if (s.pc >= 0)  chk("pipe_pc_stat", int'(pipe_pc), s.pc);
            if (s.grp >= 0) chk("pipe_group_stat", int'(pipe_group), s.grp);
            if (s.quiet != 0) chk("pulses_quiet", int'({pipe_start, done, pipe_flush}), 0);
        end
        if (fin_req) begin
            chk("scoreboard_drained", evq.size() + stq.size(), 0);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_evt(input int kind, input int pc, input int grp, input int gd, input int c);
        evt_t e;
        e.kind = kind; e.pc = pc; e.grp = grp; e.gd = gd; e.cyc = c;
        evq.push_back(e);
    endtask

    task automatic push_stat(input int c, input int rdy, input int bsy, input int er,
                             input int gd, input int pc, input int grp, input int quiet);
        stat_t s;
        s.cyc = c; s.ready = rdy; s.busy = bsy; s.err = er;
        s.gd = gd; s.pc = pc; s.grp = grp; s.quiet = quiet;
        stq.push_back(s);
    endtask

    // Present a launch once ready; returns the cycle right after the accept edge.
    task automatic launch(input int pc, input int n, output int acc);
        int w;
        w = 0;
        while (!launch_ready && w < 100) begin
            tick();
            w++;
        end
        if (!launch_ready) begin
            $display("FAIL launch_ready_wait: got 0 expected 1 within 100 cycles");
            $fatal(1, "launch_ready never rose");
        end
        launch_valid  = 1'b1;
        launch_pc     = 8'(pc);
        launch_groups = 8'(n);
        tick();
        launch_valid  = 1'b0;
        acc = cyc;
    endtask

    // Full kernel where every group halts 'dly' cycles after its start (dly >= 2).
    task automatic kernel(input int pc, input int n, input int dly);
        int s;
        launch(pc, n, s);
        for (int g = 0; g < n; g++) begin
            push_evt(K_START, pc, g, 0, s);
            repeat (dly - 1) tick();
            pipe_halt = 1'b1;
            tick();
            pipe_halt = 1'b0;
            s = cyc;
        end
        push_evt(K_DONE, 0, 0, n, s);
        push_stat(s + 1, 1, 0, 0, n, -1, -1, 1);
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish by 1ms");
        $fatal(1, "timeout");
    end

    initial begin
        int s;

        // Reset values while rst is held.
        repeat (3) tick();
        push_stat(cyc, 1, 0, 0, 0, 0, 0, 1);
        tick();
        rst = 1'b0;
        tick();

        // Single group, halt 5 cycles after start.
        kernel(8'h10, 1, 5);

        // Three groups, halt 3 cycles after each start.
        kernel(8'h30, 3, 3);

        // Zero groups: done in the cycle after accept, never busy.
        launch(8'h44, 0, s);
        push_evt(K_DONE, 0, 0, 0, s);
        push_stat(s + 1, 1, 0, 0, 0, -1, -1, 1);
        repeat (3) tick();

        // Halt on the watchdog limit cycle wins over the error.
        kernel(8'h70, 1, 21);

        // Watchdog: no halt, error after 20 RUN cycles, then err_clear.
        launch(8'h60, 2, s);
        push_evt(K_START, 8'h60, 0, 0, s);
        push_evt(K_FLUSH, 0, 0, 0, s + 21);
        push_stat(s + 21, 0, 0, 1, 0, -1, -1, 0);
        push_stat(s + 25, 0, 0, 1, 0, 8'h60, 0, 1);
        repeat (26) tick();
        push_stat(s + 26, 0, 0, 1, 0, -1, -1, 1);
        push_stat(s + 27, 1, 0, 0, 0, -1, -1, 1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        repeat (2) tick();

        // Abort coincident with halt of group 1.
        launch(8'h40, 4, s);
        push_evt(K_START, 8'h40, 0, 0, s);
        repeat (2) tick();
        pipe_halt = 1'b1;
        tick();
        pipe_halt = 1'b0;
        s = cyc;
        push_evt(K_START, 8'h40, 1, 0, s);
        repeat (2) tick();
        pipe_halt = 1'b1;
        abort = 1'b1;
        tick();
        pipe_halt = 1'b0;
        abort = 1'b0;
        s = cyc;
        push_evt(K_FLUSH, 0, 0, 1, s);
        push_stat(s + 8, 1, 0, 0, 1, 8'h40, 1, 1);
        repeat (10) tick();

        // Async reset during RUN of group 2, then a fresh launch.
        launch(8'h55, 3, s);
        for (int g = 0; g < 2; g++) begin
            push_evt(K_START, 8'h55, g, 0, s);
            repeat (2) tick();
            pipe_halt = 1'b1;
            tick();
            pipe_halt = 1'b0;
            s = cyc;
        end
        push_evt(K_START, 8'h55, 2, 0, s);
        repeat (2) tick();
        #1;
        rst = 1'b1;
        push_stat(cyc, 1, 0, 0, 0, 0, 0, 1);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        kernel(8'h22, 1, 4);

        // Maximum group count: no index wrap.
        kernel(8'h80, 255, 2);

        repeat (3) tick();
        fin_req = 1'b1;
    end

endmodule

// File: doc/shader_dispatch_ctrl.md
Name: shader_dispatch_ctrl

Overview:
Dispatch controller that sequences the SIMD shader pipeline through a kernel launch. It accepts a launch request (start PC, group count) and issues one pipeline start per thread group. It waits for the pipeline's halt, advances to the next group, and signals completion. A watchdog and an abort path recover from hung or cancelled kernels. It sits between the host/command interface and shader_pipeline.

Parameters:
PC_W, 8, width of program counter / start PC
GRP_W, 8, width of group count and group index
WDOG_W, 16, width of watchdog counter
WDOG_LIMIT, 16'd1000, RUN cycles without halt before error

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
launch_valid  in  1  launch request valid
launch_ready  out  1  controller can accept a launch
launch_pc  in  PC_W  kernel start PC
launch_groups  in  GRP_W  number of thread groups to run
abort  in  1  cancel the running kernel
err_clear  in  1  clear the sticky error and return to IDLE
pipe_start  out  1  one-cycle start pulse to the pipeline
pipe_pc  out  PC_W  start PC presented with pipe_start
pipe_group  out  GRP_W  current group index
pipe_halt  in  1  pipeline reached its halt instruction
pipe_flush  out  1  one-cycle flush pulse to the pipeline
busy  out  1  kernel in progress (ISSUE or RUN)
done  out  1  one-cycle kernel-complete pulse
err  out  1  sticky watchdog error
groups_done  out  GRP_W  count of groups completed in the current kernel

Behaviour:
- Reset, asynchronous: state=IDLE. pipe_start, pipe_flush, done, err, busy=0. pipe_pc, pipe_group, groups_done=0. Latched PC and group count=0.
- States: IDLE, ISSUE, RUN, DONE, ERROR.
- launch_ready = (state==IDLE), purely from state. A launch is accepted on the edge where launch_valid && launch_ready. The controller latches launch_pc and launch_groups, and clears groups_done and the group index.
- IDLE -> ISSUE on accept when launch_groups != 0. IDLE -> DONE on accept when launch_groups == 0; no pipe_start is issued.
- ISSUE, one cycle: pipe_start=1, pipe_pc=latched PC, pipe_group=current index. The watchdog clears. Next state is RUN. pipe_halt is ignored in this cycle.
- RUN: the watchdog increments each cycle.
  - On pipe_halt: groups_done increments.
  - If index == groups-1 -> DONE. Otherwise index increments -> ISSUE.
- Watchdog: if the counter reaches WDOG_LIMIT in RUN with no pipe_halt -> ERROR, and pipe_flush=1 for that transition cycle. pipe_halt in the same cycle as the limit wins: it is treated as a normal halt, with no error.
- ERROR: err=1, held. launch_ready=0. Leaves on err_clear -> IDLE; err deasserts in that next cycle.
- DONE, one cycle: done=1 -> IDLE. groups_done holds its final value until the next accept.
- abort in ISSUE or RUN -> IDLE with pipe_flush=1 for one cycle. No done is asserted, and groups_done holds. abort has priority over pipe_halt and the watchdog. abort in IDLE, DONE or ERROR is ignored.
- busy = (state==ISSUE || state==RUN).
- Latency:
  - Launch accept at edge N -> pipe_start high in cycle N+1.
  - Halt sampled at edge M -> next pipe_start, or done, in cycle M+1.
  - Per-group overhead is one ISSUE cycle.
- Group index arithmetic is unsigned GRP_W. launch_groups=2^GRP_W-1 is legal and produces no wrap.
- pipe_pc and pipe_group are registered and hold their values outside ISSUE.
- rst asserted mid-kernel: immediate return to reset values. No flush pulse is generated; the pipeline shares rst.

Decomposition:
- shader_pkg.vh holds the state encodings (3-bit localparams S_IDLE..S_ERROR) and the default PC_W/GRP_W widths. These are shared with shader_pipeline.
- One sub-module, shader_wdog. It provides a clear/enable counter with a terminal-count flag at WDOG_LIMIT.
- The FSM, latches and group counter live in shader_dispatch_ctrl.

Test Plan:
- Single group:
  - Stimulus: launch pc=8'h10, groups=1; pipe_halt 5 cycles after pipe_start.
  - Required response: exactly one pipe_start, with pipe_pc=10 and pipe_group=0; done in the cycle after halt; groups_done=1; launch_ready high again after done.
- Multi-group:
  - Stimulus: groups=3; each halt arrives 3 cycles after its start.
  - Required response: three pipe_start pulses with pipe_group 0,1,2; each start in the cycle after the prior halt; done once; groups_done=3.
- Zero groups:
  - Stimulus: launch with groups=0.
  - Required response: no pipe_start; done high in the cycle after accept; busy never asserts.
- Watchdog:
  - Stimulus: WDOG_LIMIT=20, groups=2; never halt.
  - Required response: err and a single pipe_flush pulse after 20 RUN cycles; launch_ready=0 until err_clear; IDLE the cycle after err_clear.
- Abort vs halt:
  - Stimulus: groups=4; abort asserted in the same cycle as pipe_halt of group 1.
  - Required response: pipe_flush pulse; no further pipe_start; no done; groups_done=1; state IDLE.
- Async reset:
  - Stimulus: rst asserted mid-edge during RUN of group 2.
  - Required response: outputs go to reset values immediately, without waiting for clk; a launch afterwards restarts at group 0.
